// File: rtl/param_tff_counter_if.sv
// Control and status bundle for param_tff_counter.
// The master drives the count controls; the slave (the counter) returns Q/TC/OVF.
interface param_tff_counter_if #(
  parameter int WIDTH = 4
);
  logic             T;
  logic             UP;
  logic             SAT;
  logic             LOAD;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             TC;
  logic             OVF;

  modport master (
    output T, UP, SAT, LOAD, D,
    input  Q, TC, OVF
  );

  modport slave (
    input  T, UP, SAT, LOAD, D,
    output Q, TC, OVF
  );
endinterface

// File: rtl/param_tff_counter.sv
// Fully synchronous up/down counter with modulus, parallel load, wrap/saturate,
// a registered terminal-count pulse and a sticky overflow flag. Updates on falling CLK.
module param_tff_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX       = 2**WIDTH-1,
  parameter int RESET_VAL = 0
) (
  input logic                CLK,
  input logic                RESET,
  param_tff_counter_if.slave cnt
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_nxt;
  logic             tc;
  logic             tc_nxt;
  logic             ovf;
  logic             ovf_nxt;

  always_comb begin
    q_nxt   = q;
    tc_nxt  = 1'b0;
    ovf_nxt = ovf;
    if (cnt.LOAD) begin
      // Clip so Q never leaves 0..MAX; keeps the WIDTH-bit compares exact.
      q_nxt   = (cnt.D > MAX_V) ? MAX_V : cnt.D;
      ovf_nxt = 1'b0;
    end else if (cnt.T) begin
      if (cnt.UP) begin
        if (q == MAX_V) begin
          q_nxt   = cnt.SAT ? MAX_V : '0;
          tc_nxt  = 1'b1;
          ovf_nxt = 1'b1;
        end else begin
          q_nxt = q + WIDTH'(1);
        end
      end else begin
        if (q == '0) begin
          q_nxt   = cnt.SAT ? '0 : MAX_V;
          tc_nxt  = 1'b1;
          ovf_nxt = 1'b1;
        end else begin
          q_nxt = q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(negedge CLK or negedge RESET) begin
    if (!RESET) begin
      q   <= RST_V;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      q   <= q_nxt;
      tc  <= tc_nxt;
      ovf <= ovf_nxt;
    end
  end

  assign cnt.Q   = q;
  assign cnt.TC  = tc;
  assign cnt.OVF = ovf;

endmodule

// File: tb/tb_param_tff_counter.sv
// Scoreboard bench for param_tff_counter: a 0..15 instance (A) and a decade
// instance with RESET_VAL=5 (B). Stimulus pushes expectations, a monitor checks them.
`timescale 1ns/1ps
module tb_param_tff_counter;

  logic clk = 1'b0;
  logic reset_a;
  logic reset_b;

  always #5 clk = ~clk;

  param_tff_counter_if #(.WIDTH(4)) if_a ();
  param_tff_counter_if #(.WIDTH(4)) if_b ();

  param_tff_counter #(.WIDTH(4)) dut_a (
    .CLK   (clk),
    .RESET (reset_a),
    .cnt   (if_a)
  );

  param_tff_counter #(.WIDTH(4), .MAX(9), .RESET_VAL(5)) dut_b (
    .CLK   (clk),
    .RESET (reset_b),
    .cnt   (if_b)
  );

  typedef struct {
    bit         sel;
    logic [3:0] q;
    logic       tc;
    logic       ovf;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   done     = 1'b0;

  task automatic push(input bit sel, input logic [3:0] q, input logic tc,
                      input logic ovf, input string name);
    exp_t e;
    e.sel  = sel;
    e.q    = q;
    e.tc   = tc;
    e.ovf  = ovf;
    e.name = name;
    sb.push_back(e);
  endtask

  // The unselected counter gets T=0/LOAD=0 so it simply holds.
  task automatic drive(input bit sel, input logic load, input logic t,
                       input logic up, input logic sat, input logic [3:0] d);
    if_a.LOAD = sel ? 1'b0 : load;
    if_a.T    = sel ? 1'b0 : t;
    if_a.UP   = up;
    if_a.SAT  = sat;
    if_a.D    = d;
    if_b.LOAD = sel ? load : 1'b0;
    if_b.T    = sel ? t : 1'b0;
    if_b.UP   = up;
    if_b.SAT  = sat;
    if_b.D    = d;
  endtask

  task automatic step(input bit sel, input logic load, input logic t,
                      input logic up, input logic sat, input logic [3:0] d,
                      input logic [3:0] eq, input logic etc, input logic eovf,
                      input string name);
    @(posedge clk);
    #1;
    drive(sel, load, t, up, sat, d);
    @(negedge clk);
    #1;
    push(sel, eq, etc, eovf, name);
  endtask

  // Monitor: outputs are sampled on the rising edge, away from the active falling edge.
  initial begin : monitor
    exp_t       e;
    logic [3:0] aq;
    logic       atc;
    logic       aovf;
    forever begin
      @(posedge clk);
      if (sb.size() > 0) begin
        e    = sb.pop_front();
        aq   = e.sel ? if_b.Q   : if_a.Q;
        atc  = e.sel ? if_b.TC  : if_a.TC;
        aovf = e.sel ? if_b.OVF : if_a.OVF;
        n_checks++;
        if (aq === e.q) n_pass++;
        else $display("FAIL %s Q: got %0d expected %0d", e.name, aq, e.q);
        n_checks++;
        if (atc === e.tc) n_pass++;
        else $display("FAIL %s TC: got %b expected %b", e.name, atc, e.tc);
        n_checks++;
        if (aovf === e.ovf) n_pass++;
        else $display("FAIL %s OVF: got %b expected %b", e.name, aovf, e.ovf);
      end else if (done) begin
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, expected summary before 100us");
    $fatal(1);
  end

  initial begin : stimulus
    int t2q [9];
    t2q = '{6, 5, 4, 3, 2, 1, 0, 9, 8};

    reset_a = 1'b0;
    reset_b = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    #1;
    push(1'b0, 4'd0, 1'b0, 1'b0, "rst_a");
    @(posedge clk);
    #1;
    push(1'b1, 4'd5, 1'b0, 1'b0, "rst_b");
    @(posedge clk);
    #1;
    reset_a = 1'b1;
    reset_b = 1'b1;

    // A: count up through 15->0 wrap
    for (int k = 1; k <= 17; k++)
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'(k % 16), (k == 16), (k >= 16), "t1_up_wrap");

    // A: continue to 6, then asynchronous reset between edges
    for (int k = 2; k <= 6; k++)
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'(k), 1'b0, 1'b1, "t5_count");
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    #2;
    reset_a = 1'b0;
    #1;
    push(1'b0, 4'd0, 1'b0, 1'b0, "t5_async_rst");
    @(posedge clk);
    #1;
    reset_a = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0, "t5_resume");

    // B: decade down-count with wrap, then clipped load
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 4'd7, 1'b0, 1'b0, "t2_load7");
    for (int i = 0; i < 9; i++)
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'(t2q[i]), (i == 7), (i >= 7), "t2_down_wrap");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd12, 4'd9, 1'b0, 1'b0, "t2_load_clip");

    // B: saturate at MAX, then at 0
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd8, 4'd8, 1'b0, 1'b0, "t3_load8");
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 4'd9, 1'b0, 1'b0, "t3_up_to_max");
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 4'd9, 1'b1, 1'b1, "t3_sat_max");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, "t3_load0");
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b1, "t3_sat_zero");

    // B: load beats T, then direction flips every edge
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 4'd5, 1'b0, 1'b0, "t4_load5");
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 4'd3, 1'b0, 1'b0, "t4_load_wins");
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 1'b1, (i % 2 == 0), 1'b0, 4'd0, (i % 2 == 0) ? 4'd4 : 4'd3,
           1'b0, 1'b0, "t4_dir_toggle");

    // B: wrap 9->0 to set OVF, count to 5, then hold with UP/SAT toggling
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd9, 4'd9, 1'b0, 1'b0, "t6_load9");
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, "t6_up_wrap");
    for (int k = 1; k <= 5; k++)
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'(k), 1'b0, 1'b1, "t6_count");
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b0, 1'b0, (i % 2 == 1), (i % 2 == 0), 4'd0, 4'd5, 1'b0, 1'b1, "t6_hold");

    done = 1'b1;
  end

endmodule
